// File: rtl/traffic_pkg.sv
// Shared definitions for the farm-road traffic light slice: default timing
// constants, vehicle-detection states and controller light-state codes.
package traffic_pkg;

    localparam int DEF_DEBOUNCE_CYCLES    = 8;
    localparam int DEF_MIN_PRESENCE_TICKS = 2;
    localparam int DEF_QUEUE_MAX          = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        COUNTED = 2'd2,
        RELEASE = 2'd3
    } det_state_t;

    typedef enum logic [1:0] {
        HWY_GREEN   = 2'd0,
        HWY_YELLOW  = 2'd1,
        FARM_GREEN  = 2'd2,
        FARM_YELLOW = 2'd3
    } light_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a level debouncer: dout follows the
// synchronized input only after it has disagreed for DEBOUNCE_CYCLES cycles.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_ff;
    logic [CNT_W-1:0] cnt;

    // The count never passes CNT_LAST: reaching it flips dout and restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
            cnt     <= '0;
            dout    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], din};
            if (sync_ff[1] != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync_ff[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vehicle_request_unit.sv
// Farm-road vehicle detector: debounces the loop sensor, counts each vehicle
// once after enough presence ticks, and keeps a saturating waiting queue.
module vehicle_request_unit
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_PRESENCE_TICKS = DEF_MIN_PRESENCE_TICKS,
    parameter int QUEUE_MAX          = DEF_QUEUE_MAX,
    localparam int QUEUE_W           = $clog2(QUEUE_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               sensor_raw,
    input  logic               serve,
    input  logic               clr_ovf,
    output logic               req,
    output logic [QUEUE_W-1:0] queue_len,
    output logic               overflow
);

    localparam int PRES_W = $clog2(MIN_PRESENCE_TICKS + 1);
    localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(MIN_PRESENCE_TICKS - 1);
    localparam logic [PRES_W-1:0] PRES_MAX  = PRES_W'(MIN_PRESENCE_TICKS);
    localparam logic [QUEUE_W-1:0] Q_MAX    = QUEUE_W'(QUEUE_MAX);

    logic               debounced;
    det_state_t         state, state_next;
    logic [PRES_W-1:0]  pres_cnt, pres_next;
    logic               arrival;
    logic [QUEUE_W-1:0] queue_next;
    logic               ovf_next;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sensor_raw),
        .dout (debounced)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pres_cnt <= '0;
        end else begin
            state    <= state_next;
            pres_cnt <= pres_next;
        end
    end

    always_comb begin
        state_next = state;
        pres_next  = pres_cnt;
        case (state)
            IDLE: begin
                if (debounced) begin
                    state_next = ARM;
                    pres_next  = '0;
                end
            end
            ARM: begin
                if (!debounced) begin
                    state_next = IDLE;
                    pres_next  = '0;
                end else if (tick) begin
                    if (pres_cnt >= PRES_LAST) begin
                        state_next = COUNTED;
                        pres_next  = PRES_MAX;
                    end else begin
                        pres_next = pres_cnt + PRES_W'(1);
                    end
                end
            end
            COUNTED: begin
                if (!debounced) state_next = RELEASE;
            end
            RELEASE: begin
                // A returning presence before the tick is the same vehicle.
                if (debounced)  state_next = COUNTED;
                else if (tick)  state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                pres_next  = '0;
            end
        endcase
    end

    always_comb begin
        arrival = (state == ARM) && debounced && tick && (pres_cnt >= PRES_LAST);
    end

    // A serve empties the queue; a coincident arrival is the first new waiter.
    always_comb begin
        queue_next = queue_len;
        ovf_next   = overflow;
        if (clr_ovf) ovf_next = 1'b0;
        if (serve) begin
            queue_next = arrival ? QUEUE_W'(1) : '0;
        end else if (arrival) begin
            if (queue_len < Q_MAX) queue_next = queue_len + QUEUE_W'(1);
            else                   ovf_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_len <= '0;
            req       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            queue_len <= queue_next;
            req       <= (queue_next != '0);
            overflow  <= ovf_next;
        end
    end

endmodule
